// File: rtl/text_mode_ctrl_if.sv
// Host write channel into the text-mode character RAM.
//   wr_valid : host request, held with addr/data stable until accepted
//   wr_ready : controller accepts on the edge where wr_valid && wr_ready
//   wr_addr  : cell index = row*80 + col (indices >= 2400 are accepted and dropped)
//   wr_data  : character code
// master = host side, slave = text_mode_ctrl side.
interface text_mode_ctrl_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/text_mode_ctrl.sv
// 80x30 text-mode controller (640x480 active in an 800x525 frame, 8x16 cells).
// Owns the 2400x8 character RAM, shares it between host writes and video
// fetches, and sequences font_rom lookups one cell ahead of the beam.
//
// Ports
//   clk_25mhz  in   pixel clock (only clock)
//   reset      in   asynchronous, active-high
//   x, y       in   beam position from hdmi_video (0..799, 0..524)
//   color      out  24-bit pixel color for (x,y), combinational
//   font_addr  out  {char, glyph_row} to font_rom, registered
//   font_data  in   font_rom row bits, 1-cycle latency, MSB = leftmost pixel
//   wr         slave modport of text_mode_ctrl_if (host write channel)
//   cursor_col, cursor_row  in  cursor cell (only with TEXT_CURSOR_EN)
//
// Optional feature: define TEXT_CURSOR_EN to add a blinking underline cursor
// (glyph rows 14/15 forced on) driven by a 4-bit frame counter.
module text_mode_ctrl #(
  parameter logic [23:0] FG_COLOR = 24'h00ff00,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [23:0]   color,
  output logic [11:0]   font_addr,
  input  logic [7:0]    font_data,
`ifdef TEXT_CURSOR_EN
  input  logic [6:0]    cursor_col,
  input  logic [4:0]    cursor_row,
`endif
  text_mode_ctrl_if.slave wr
);
  localparam int unsigned CELLS = 2400;

  logic [2:0] slot;
  assign slot = x[2:0];

  // ---------------------------------------------------------------------------
  // Fetch target: always the cell after the one under the beam. The last cell
  // of a line (x >= 792) targets column 0 of the following line.
  // ---------------------------------------------------------------------------
  logic [9:0]  ty;
  logic [6:0]  tcol;
  logic [5:0]  trow;
  logic [3:0]  grow;
  logic        blank;
  logic [11:0] fetch_addr;

  always_comb begin
    if (x < 10'd792) begin
      tcol = x[9:3] + 7'd1;
      ty   = y;
    end else begin
      tcol = 7'd0;
      ty   = (y == 10'd524) ? 10'd0 : y + 10'd1;
    end
    trow  = ty[9:4];
    grow  = ty[3:0];
    // Off-screen targets still walk the pipeline; their row bits are zeroed.
    blank = (tcol >= 7'd80) || (ty >= 10'd480);
    // row*80 as shift-add: row*64 + row*16 + col
    fetch_addr = {trow, 6'b0} + {2'b0, trow, 4'b0} + {5'b0, tcol};
  end

  // ---------------------------------------------------------------------------
  // Character RAM. Single port: slot 3 belongs to the video read, every other
  // slot to the host. Contents are never reset; power-up fill is spaces.
  // ---------------------------------------------------------------------------
  logic [7:0] mem [0:CELLS-1] = '{default: 8'h20};
  logic [7:0] char_q;
  logic       rdy_en_q, rdy_en_d;
  logic       wr_commit;

  // rdy_en_q holds wr_ready low through reset and until the first edge after it.
  assign wr.wr_ready = rdy_en_q && (slot != 3'd3);
  assign wr_commit   = wr.wr_valid && wr.wr_ready && (wr.wr_addr < 12'(CELLS));

  always_ff @(posedge clk_25mhz) begin
    if (wr_commit)
      mem[wr.wr_addr] <= wr.wr_data;
    // Reads beyond the array only happen for blanked targets; skip them.
    if (slot == 3'd3 && fetch_addr < 12'(CELLS))
      char_q <= mem[fetch_addr];
  end

  // ---------------------------------------------------------------------------
  // Glyph byte source (cursor overlay when enabled)
  // ---------------------------------------------------------------------------
  logic [7:0] fetch_byte;

`ifdef TEXT_CURSOR_EN
  logic [3:0] frame_q, frame_d;
  logic       cursor_hit;

  always_comb begin
    frame_d = frame_q;
    if (x == 10'd799 && y == 10'd524)
      frame_d = frame_q + 4'd1;
  end

  // Visible while frame_q[3] == 0; out-of-range cursor positions never match.
  always_comb begin
    cursor_hit = (frame_q[3] == 1'b0) &&
                 (cursor_col < 7'd80) && (cursor_row < 5'd30) &&
                 (tcol == cursor_col) && (trow == {1'b0, cursor_row}) &&
                 (grow[3:1] == 3'b111);
    fetch_byte = cursor_hit ? 8'hFF : font_data;
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) frame_q <= 4'd0;
    else       frame_q <= frame_d;
  end
`else
  assign fetch_byte = font_data;
`endif

  // ---------------------------------------------------------------------------
  // Fetch pipeline
  //   slot 3 edge : char_q <= RAM
  //   slot 4 edge : font_addr <= {char, glyph_row}
  //   slot 6 edge : pending <= font row (or 0 if blanked / no valid fetch yet)
  //   slot 7 edge : current <= pending
  // fetch_vld_q marks that a RAM read has happened since reset, so a partial
  // fetch straddling reset release is shown as background.
  // ---------------------------------------------------------------------------
  logic [11:0] font_addr_q, font_addr_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  current_q, current_d;
  logic        fetch_vld_q, fetch_vld_d;

  always_comb begin
    rdy_en_d    = 1'b1;
    fetch_vld_d = fetch_vld_q | (slot == 3'd3);
    font_addr_d = font_addr_q;
    pending_d   = pending_q;
    current_d   = current_q;
    if (slot == 3'd4) font_addr_d = {char_q, grow};
    if (slot == 3'd6) pending_d   = (fetch_vld_q && !blank) ? fetch_byte : 8'h00;
    if (slot == 3'd7) current_d   = pending_q;
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      rdy_en_q    <= 1'b0;
      fetch_vld_q <= 1'b0;
      font_addr_q <= 12'd0;
      pending_q   <= 8'd0;
      current_q   <= 8'd0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      fetch_vld_q <= fetch_vld_d;
      font_addr_q <= font_addr_d;
      pending_q   <= pending_d;
      current_q   <= current_d;
    end
  end

  assign font_addr = font_addr_q;

  // ---------------------------------------------------------------------------
  // Pixel color: black outside the active area, glyph bit select inside.
  // ---------------------------------------------------------------------------
  always_comb begin
    color = 24'h000000;
    if (x < 10'd640 && y < 10'd480)
      color = current_q[3'd7 - slot] ? FG_COLOR : BG_COLOR;
  end

endmodule
